// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer and status block of the dual-clock FIFO.
// Synchronizes the Gray write pointer and owns the read pointer and flags.
module rd_pntrs_and_empty #(
  parameter int AWIDTH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              rd_clk_i,
  input  logic              sclr_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic              rd_en_o,
  output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
  output logic              rd_empty_o,
  output logic              rd_almost_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic              rd_underflow_o
);

  localparam logic [AWIDTH:0] AE_THR = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0] ONE    = (AWIDTH+1)'(1);

  logic [AWIDTH:0] sync_q [SYNC_STAGES];

  logic [AWIDTH:0] rd_pntr_bin_q, rd_pntr_bin_d;
  logic [AWIDTH:0] rd_gray_q, rd_gray_d;
  logic [AWIDTH:0] usedw_q, usedw_d;
  logic            empty_q, empty_d;
  logic            ae_q, ae_d;
  logic            underflow_q, underflow_d;

  logic [AWIDTH:0] wr_gray_sync;
  logic [AWIDTH:0] wr_bin_sync;

  always_comb begin
    wr_gray_sync = sync_q[SYNC_STAGES-1];
    wr_bin_sync  = '0;
    wr_bin_sync[AWIDTH] = wr_gray_sync[AWIDTH];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      wr_bin_sync[i] = wr_bin_sync[i+1] ^ wr_gray_sync[i];
    end

    rd_en_o       = rd_req_i & ~empty_q;
    rd_pntr_bin_d = rd_en_o ? rd_pntr_bin_q + ONE : rd_pntr_bin_q;
    rd_gray_d     = rd_pntr_bin_d ^ (rd_pntr_bin_d >> 1);

    // Status uses the post-read pointer, so it can only be pessimistic
    empty_d     = (rd_gray_d == wr_gray_sync);
    usedw_d     = wr_bin_sync - rd_pntr_bin_d;
    ae_d        = (usedw_d <= AE_THR);
    underflow_d = underflow_q | (rd_req_i & empty_q);
  end

  always_ff @(posedge rd_clk_i) begin
    if (sclr_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_pntr_bin_q <= '0;
      rd_gray_q     <= '0;
      usedw_q       <= '0;
      empty_q       <= 1'b1;
      ae_q          <= 1'b1;
      underflow_q   <= 1'b0;
    end else begin
      sync_q[0] <= wr_pntr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rd_pntr_bin_q <= rd_pntr_bin_d;
      rd_gray_q     <= rd_gray_d;
      usedw_q       <= usedw_d;
      empty_q       <= empty_d;
      ae_q          <= ae_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rd_pntr_o         = rd_pntr_bin_q[AWIDTH-1:0];
  assign rd_pntr_gray_wr_o = rd_gray_q;
  assign rd_empty_o        = empty_q;
  assign rd_almost_empty_o = ae_q;
  assign rd_usedw_o        = usedw_q;
  assign rd_underflow_o    = underflow_q;

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Directed bench for rd_pntrs_and_empty with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rd_pntrs_and_empty;

  logic       clk = 1'b0;
  logic       sclr;
  logic       req;
  logic [4:0] wr_gray;
  logic [3:0] pntr;
  logic       en;
  logic [4:0] gray_wr;
  logic       empty;
  logic       ae;
  logic [4:0] usedw;
  logic       uf;

  int n_run  = 0;
  int n_fail = 0;

  rd_pntrs_and_empty #(
    .AWIDTH(4),
    .SYNC_STAGES(2),
    .AE_LEVEL(2)
  ) dut (
    .rd_clk_i(clk),
    .sclr_i(sclr),
    .rd_req_i(req),
    .wr_pntr_gray_i(wr_gray),
    .rd_pntr_o(pntr),
    .rd_en_o(en),
    .rd_pntr_gray_wr_o(gray_wr),
    .rd_empty_o(empty),
    .rd_almost_empty_o(ae),
    .rd_usedw_o(usedw),
    .rd_underflow_o(uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sclr    = 1'b1;
    req     = 1'b0;
    wr_gray = 5'b00000;
    tick();
    sclr = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_ae", ae, 1);
    chk("rst_usedw", usedw, 0);
    chk("rst_pntr", pntr, 0);
    chk("rst_gray", gray_wr, 0);
    chk("rst_uf", uf, 0);

    // Fill: bin 3 = gray 00010, visible on the 3rd edge
    wr_gray = 5'b00010;
    tick();
    tick();
    chk("fill_e2_empty", empty, 1);
    chk("fill_e2_usedw", usedw, 0);
    tick();
    chk("fill_e3_empty", empty, 0);
    chk("fill_e3_usedw", usedw, 3);
    chk("fill_e3_ae", ae, 0);

    // Drain three words
    req = 1'b1;
    #1;
    chk("drain0_en", en, 1);
    chk("drain0_pntr", pntr, 0);
    tick();
    chk("drain1_en", en, 1);
    chk("drain1_pntr", pntr, 1);
    chk("drain1_usedw", usedw, 2);
    chk("drain1_ae", ae, 1);
    chk("drain1_empty", empty, 0);
    tick();
    chk("drain2_en", en, 1);
    chk("drain2_pntr", pntr, 2);
    chk("drain2_usedw", usedw, 1);
    tick();
    chk("drained_pntr", pntr, 3);
    chk("drained_gray", gray_wr, 5'b00010);
    chk("drained_empty", empty, 1);
    chk("drained_usedw", usedw, 0);
    chk("drained_en", en, 0);
    chk("drained_uf", uf, 0);

    // Underflow: request held while empty
    tick();
    chk("uf_set", uf, 1);
    chk("uf_pntr", pntr, 3);
    chk("uf_en", en, 0);
    req = 1'b0;
    tick();
    tick();
    chk("uf_sticky", uf, 1);

    // Full and wrap from pointer 0
    sclr    = 1'b1;
    wr_gray = 5'b00000;
    tick();
    sclr = 1'b0;
    chk("rst2_uf", uf, 0);
    chk("rst2_pntr", pntr, 0);
    wr_gray = 5'b11000;
    tick();
    tick();
    tick();
    chk("full_usedw", usedw, 16);
    chk("full_empty", empty, 0);
    chk("full_ae", ae, 0);
    req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("wrap_pntr%0d", i), pntr, i % 16);
      chk($sformatf("wrap_usedw%0d", i), usedw, 16 - i);
    end
    chk("wrap_gray", gray_wr, 5'b11000);
    chk("wrap_empty", empty, 1);
    chk("wrap_en", en, 0);
    req = 1'b0;

    // Reset mid-operation: bin 21 = gray 11111, pointer at 16
    wr_gray = 5'b11111;
    tick();
    tick();
    tick();
    chk("mid_usedw", usedw, 5);
    chk("mid_empty", empty, 0);
    req  = 1'b1;
    sclr = 1'b1;
    tick();
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ae", ae, 1);
    chk("mid_rst_usedw", usedw, 0);
    chk("mid_rst_pntr", pntr, 0);
    chk("mid_rst_gray", gray_wr, 0);
    chk("mid_rst_uf", uf, 0);
    tick();
    chk("rst_hold_uf", uf, 0);
    chk("rst_hold_pntr", pntr, 0);
    sclr = 1'b0;
    req  = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
